// File: rtl/sift_line_buffer3_pkg.sv
// Shared defaults and index typedefs for the SIFT three-row line buffer.
package sift_line_buffer3_pkg;

  localparam int PIX_W_DEF      = 9;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  localparam int COL_W_DEF = $clog2(IMG_WIDTH_DEF);
  localparam int ROW_W_DEF = $clog2(IMG_HEIGHT_DEF);

  typedef logic [COL_W_DEF-1:0] col_t;
  typedef logic [ROW_W_DEF-1:0] row_t;

  // Index width for a counter covering 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sift_line_buffer3_if.sv
// Pixel stream in / aligned column triple out for the SIFT line buffer.
interface sift_line_buffer3_if
  import sift_line_buffer3_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int COL_W = COL_W_DEF
) ();

  logic             ivalid;
  logic             isof;
  logic [PIX_W-1:0] idata;
  logic             ovalid;
  logic [PIX_W-1:0] odata0;
  logic [PIX_W-1:0] odata1;
  logic [PIX_W-1:0] odata2;
  logic [COL_W-1:0] ocol;
  logic             oframe_done;

  modport master (
    output ivalid, isof, idata,
    input  ovalid, odata0, odata1, odata2, ocol, oframe_done
  );

  modport slave (
    input  ivalid, isof, idata,
    output ovalid, odata0, odata1, odata2, ocol, oframe_done
  );

endinterface

// File: rtl/sift_line_buffer3_line_ram.sv
// Single-port line RAM: combinational read of the old word, write on the clock edge.
module lb_line_ram #(
  parameter int DEPTH  = 640,
  parameter int PIX_W  = 9,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sift_line_buffer3.sv
// Three-row line buffer: emits (row r, r-1, r-2) pixels per column with one cycle latency.
// Optional top-border replication when LB_TOP_REPLICATE_EN is defined.
module sift_line_buffer3
  import sift_line_buffer3_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int PIX_W      = PIX_W_DEF
) (
  input logic              iclk,
  input logic              irst,
  sift_line_buffer3_if.slave bus
);

  localparam int COL_W = idx_w(IMG_WIDTH);
  localparam int ROW_W = idx_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col_cur;
  logic [ROW_W-1:0] row_cur;
  logic             col_wrap;
  logic             row_last;
  logic [PIX_W-1:0] l0_rd;
  logic [PIX_W-1:0] l1_rd;

  // isof forces the current pixel to (0,0) regardless of where the counters are
  assign col_cur  = bus.isof ? '0 : col;
  assign row_cur  = bus.isof ? '0 : row;
  assign col_wrap = (col_cur == COL_LAST);
  assign row_last = (row_cur == ROW_LAST);

  lb_line_ram #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W), .ADDR_W(COL_W)) u_l0 (
    .clk   (iclk),
    .we    (bus.ivalid),
    .addr  (col_cur),
    .wdata (bus.idata),
    .rdata (l0_rd)
  );

  // L1 is fed with the word L0 is about to lose, so it trails L0 by one row
  lb_line_ram #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W), .ADDR_W(COL_W)) u_l1 (
    .clk   (iclk),
    .we    (bus.ivalid),
    .addr  (col_cur),
    .wdata (l0_rd),
    .rdata (l1_rd)
  );

  // ---- stage p0: tap selection ----
  logic             vld_p0;
  logic [PIX_W-1:0] tap1_p0;
  logic [PIX_W-1:0] tap2_p0;

`ifdef LB_TOP_REPLICATE_EN
  logic row_zero;
  logic row_one;
  assign row_zero = (row_cur == '0);
  assign row_one  = (row_cur == ROW_W'(1));

  always_comb begin
    vld_p0  = bus.ivalid;
    tap1_p0 = row_zero ? bus.idata : l0_rd;
    tap2_p0 = row_zero ? bus.idata : (row_one ? l0_rd : l1_rd);
  end
`else
  always_comb begin
    vld_p0  = bus.ivalid && (row_cur >= ROW_TWO);
    tap1_p0 = l0_rd;
    tap2_p0 = l1_rd;
  end
`endif

  // ---- stage p1: output registers and raster counters ----
  logic             vld_p1;
  logic             done_p1;
  logic [PIX_W-1:0] data0_p1;
  logic [PIX_W-1:0] data1_p1;
  logic [PIX_W-1:0] data2_p1;
  logic [COL_W-1:0] col_p1;

  always_ff @(posedge iclk) begin
    if (irst) begin
      col      <= '0;
      row      <= '0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      data0_p1 <= '0;
      data1_p1 <= '0;
      data2_p1 <= '0;
      col_p1   <= '0;
    end else begin
      vld_p1  <= vld_p0;
      done_p1 <= bus.ivalid && col_wrap && row_last;
      if (bus.ivalid) begin
        data0_p1 <= bus.idata;
        data1_p1 <= tap1_p0;
        data2_p1 <= tap2_p0;
        col_p1   <= col_cur;
        if (col_wrap) begin
          col <= '0;
          row <= row_last ? '0 : row_cur + 1'b1;
        end else begin
          col <= col_cur + 1'b1;
          row <= row_cur;
        end
      end
    end
  end

  assign bus.ovalid      = vld_p1;
  assign bus.oframe_done = done_p1;
  assign bus.odata0      = data0_p1;
  assign bus.odata1      = data1_p1;
  assign bus.odata2      = data2_p1;
  assign bus.ocol        = col_p1;

endmodule

// File: tb/tb_sift_line_buffer3.sv
// Bench for sift_line_buffer3 on a 4x4 image: fixed frame table, directed corner sequences, random stream vs column-history model.
module tb_sift_line_buffer3;

  localparam int W = 4;
  localparam int H = 4;

  logic iclk = 1'b0;
  logic irst = 1'b1;

  always #5 iclk = ~iclk;

  sift_line_buffer3_if #(.PIX_W(9), .COL_W(2)) bus ();

  sift_line_buffer3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(9)) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit         v;
    bit         s;
    logic [8:0] d;
    bit         ev;
    logic [8:0] e0;
    logic [8:0] e1;
    logic [8:0] e2;
    logic [1:0] ec;
    bit         edone;
  } vec_t;

  vec_t tab [2*W*H];

  // reference model state: raster position plus the last two pixels seen per column
  logic [8:0] hist [W][$];
  int         m_row = 0;
  int         m_col = 0;
  bit         e_v, e_done, k12;
  logic [8:0] e0, e1, e2;
  logic [1:0] e_col;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model(input bit v, input bit s, input logic [8:0] d, input bit r);
    int rr, cc, n;
    if (r) begin
      e_v = 0; e_done = 0; e0 = 0; e1 = 0; e2 = 0; e_col = 0;
      m_row = 0; m_col = 0; k12 = 1;
    end else if (!v) begin
      e_v = 0; e_done = 0;
    end else begin
      rr = s ? 0 : m_row;
      cc = s ? 0 : m_col;
      n  = hist[cc].size();
      e0 = d;
      e_col = 2'(cc);
      e_done = (rr == H-1) && (cc == W-1);
`ifdef LB_TOP_REPLICATE_EN
      e_v = 1;
      if (rr == 0) begin
        e1 = d; e2 = d; k12 = 1;
      end else if (rr == 1) begin
        k12 = (n >= 1);
        if (k12) begin e1 = hist[cc][n-1]; e2 = e1; end
      end else begin
        k12 = (n >= 2);
        if (k12) begin e1 = hist[cc][n-1]; e2 = hist[cc][n-2]; end
      end
`else
      e_v = (rr >= 2);
      k12 = e_v && (n >= 2);
      if (k12) begin e1 = hist[cc][n-1]; e2 = hist[cc][n-2]; end
`endif
      hist[cc].push_back(d);
      if (hist[cc].size() > 2) void'(hist[cc].pop_front());
      if (cc == W-1) begin
        m_col = 0;
        m_row = (rr == H-1) ? 0 : rr + 1;
      end else begin
        m_col = cc + 1;
        m_row = rr;
      end
    end
  endtask

  task automatic drive(input bit v, input bit s, input logic [8:0] d, input bit r);
    irst       = r;
    bus.ivalid = v;
    bus.isof   = s;
    bus.idata  = d;
    model(v, s, d, r);
    @(posedge iclk);
    #1;
  endtask

  task automatic cyc(input bit v, input bit s, input logic [8:0] d, input bit r);
    drive(v, s, d, r);
    chk("ovalid",      32'(bus.ovalid),      32'(e_v));
    chk("oframe_done", 32'(bus.oframe_done), 32'(e_done));
    chk("odata0",      32'(bus.odata0),      32'(e0));
    chk("ocol",        32'(bus.ocol),        32'(e_col));
    if (k12) begin
      chk("odata1", 32'(bus.odata1), 32'(e1));
      chk("odata2", 32'(bus.odata2), 32'(e2));
    end
  endtask

  task automatic pix(input int r, input int c, input bit s);
    cyc(1'b1, s, 9'(16*r + c), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    // two back-to-back frames of pixel value 16*row+col
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          vec_t t;
          t.v = 1; t.s = (r == 0 && c == 0);
          t.d = 9'(16*r + c);
          t.e0 = t.d; t.ec = 2'(c);
          t.edone = (r == H-1 && c == W-1);
`ifdef LB_TOP_REPLICATE_EN
          t.ev = 1;
          t.e1 = (r == 0) ? t.d : 9'(16*(r-1) + c);
          t.e2 = (r == 0) ? t.d : (r == 1) ? 9'(c) : 9'(16*(r-2) + c);
`else
          t.ev = (r >= 2);
          t.e1 = 9'(16*(r-1) + c);
          t.e2 = 9'(16*(r-2) + c);
`endif
          tab[f*W*H + r*W + c] = t;
        end

    bus.ivalid = 0; bus.isof = 0; bus.idata = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 9'd0, 1'b1);

    foreach (tab[i]) begin
      drive(tab[i].v, tab[i].s, tab[i].d, 1'b0);
      chk("tab_ovalid", 32'(bus.ovalid),      32'(tab[i].ev));
      chk("tab_done",   32'(bus.oframe_done), 32'(tab[i].edone));
      chk("tab_odata0", 32'(bus.odata0),      32'(tab[i].e0));
      if (tab[i].ev) begin
        chk("tab_odata1", 32'(bus.odata1), 32'(tab[i].e1));
        chk("tab_odata2", 32'(bus.odata2), 32'(tab[i].e2));
        chk("tab_ocol",   32'(bus.ocol),   32'(tab[i].ec));
      end
    end

    // frame with ivalid toggled every other cycle
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        pix(r, c, r == 0 && c == 0);
        cyc(1'b0, 1'b0, 9'($urandom_range(0, 511)), 1'b0);
      end

    // reset at row 2 col 2, then a new frame without isof
    for (int i = 0; i < 2*W + 2; i++) pix(i / W, i % W, i == 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 9'd0, 1'b1);
      chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
      chk("rst_odata1", 32'(bus.odata1), 32'd0);
      chk("rst_odata2", 32'(bus.odata2), 32'd0);
    end
    for (int i = 0; i < W*H; i++) pix(i / W, i % W, 1'b0);

    // isof re-asserted at row 3 col 1 aborts the frame
    for (int i = 0; i < 3*W + 1; i++) pix(i / W, i % W, i == 0);
    for (int i = 0; i < W*H; i++) pix(i / W, i % W, i == 0);

    // random stream
    for (int i = 0; i < 2000; i++) begin
      bit r, v, s;
      r = ($urandom_range(0, 199) == 0);
      v = !r && ($urandom_range(0, 9) < 7);
      s = v && ($urandom_range(0, 49) == 0);
      cyc(v, s, 9'($urandom_range(0, 511)), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
